// File: rtl/l1_cache_pkg.sv
// Shared types and address-field helpers for the set-associative L1 data cache.
package l1_cache_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_EVICT, S_REFILL_REQ, S_REFILL, S_WT_WRITE, S_RESP
  } state_e;

  // Index width for n items, never narrower than one bit.
  function automatic int clog2_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [63:0] addr_tag(input logic [63:0] a, input int idx_w, input int off_w);
    return a >> (idx_w + off_w + 2);
  endfunction

  function automatic logic [63:0] addr_idx(input logic [63:0] a, input int idx_w, input int off_w);
    return (a >> (off_w + 2)) & ((64'd1 << idx_w) - 64'd1);
  endfunction

  function automatic logic [63:0] addr_off(input logic [63:0] a, input int off_w);
    return (a >> 2) & ((64'd1 << off_w) - 64'd1);
  endfunction

endpackage

// File: rtl/cache_lru.sv
// Per-set true-LRU age tracking with invalid-way-first victim selection.
module cache_lru
  import l1_cache_pkg::*;
#(
  parameter int NUM_SETS = 16,
  parameter int NUM_WAYS = 4,
  localparam int IDX_W = clog2_w(NUM_SETS),
  localparam int WAY_W = clog2_w(NUM_WAYS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IDX_W-1:0]    set_i,
  input  logic [WAY_W-1:0]    way_i,
  input  logic                touch_i,
  input  logic [NUM_WAYS-1:0] valid_i,
  output logic [WAY_W-1:0]    victim_o
);

  logic [NUM_SETS-1:0][NUM_WAYS-1:0][WAY_W-1:0] age_q;
  logic [WAY_W-1:0] oldest, first_inv;
  logic             any_inv;

  always_comb begin
    oldest    = '0;
    first_inv = '0;
    any_inv   = 1'b0;
    // Downward scans so the lowest matching index wins.
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (age_q[set_i][w] == WAY_W'(NUM_WAYS - 1)) oldest = WAY_W'(w);
      if (!valid_i[w]) begin
        first_inv = WAY_W'(w);
        any_inv   = 1'b1;
      end
    end
    victim_o = any_inv ? first_inv : oldest;
  end

  // Ages come out of reset as the identity permutation so they stay a
  // permutation under the touch rule from the very first access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < NUM_WAYS; w++)
          age_q[s][w] <= WAY_W'(w);
    end else if (touch_i) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (WAY_W'(w) == way_i)
          age_q[set_i][w] <= '0;
        else if (age_q[set_i][w] < age_q[set_i][way_i])
          age_q[set_i][w] <= age_q[set_i][w] + 1'b1;
      end
    end
  end

endmodule

// File: rtl/l1_cache_assoc.sv
// Set-associative L1 data cache: true-LRU, write-through or write-back, and a
// single-outstanding line refill/evict engine toward the memory bus.
module l1_cache_assoc
  import l1_cache_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int NUM_SETS    = 16,
  parameter int NUM_WAYS    = 4,
  parameter int BLOCK_WORDS = 8,
  parameter bit WRITE_BACK  = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);

  localparam int OFF_W = clog2_w(BLOCK_WORDS);
  localparam int IDX_W = clog2_w(NUM_SETS);
  localparam int WAY_W = clog2_w(NUM_WAYS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 2;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(BLOCK_WORDS - 1);

  state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic [WAY_W-1:0]  victim_q;
  logic [OFF_W-1:0]  beat_q;
  logic [31:0]       hit_q, miss_q;

  logic [TAG_W-1:0]  tag_q  [NUM_SETS][NUM_WAYS];
  logic [DATA_W-1:0] data_q [NUM_SETS][NUM_WAYS][BLOCK_WORDS];
  logic [NUM_SETS-1:0][NUM_WAYS-1:0] valid_q, dirty_q;

  logic [TAG_W-1:0]    req_tag;
  logic [IDX_W-1:0]    req_idx;
  logic [OFF_W-1:0]    req_off;
  logic [NUM_WAYS-1:0] hit_vec;
  logic                hit;
  logic [WAY_W-1:0]    hit_way, victim_way, lru_way;
  logic                lru_touch;

  assign req_tag = TAG_W'(addr_tag(64'(addr_q), IDX_W, OFF_W));
  assign req_idx = IDX_W'(addr_idx(64'(addr_q), IDX_W, OFF_W));
  assign req_off = OFF_W'(addr_off(64'(addr_q), OFF_W));

  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      hit_vec[w] = valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag);
      if (hit_vec[w]) hit_way = WAY_W'(w);
    end
  end
  assign hit = |hit_vec;

  a_one_hit: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == S_LOOKUP) |-> $onehot0(hit_vec));

  // LRU is touched on a lookup hit and when a refilled line is installed.
  always_comb begin
    lru_touch = 1'b0;
    lru_way   = hit_way;
    if (state_q == S_LOOKUP && hit) begin
      lru_touch = 1'b1;
    end else if (state_q == S_REFILL && mem_rvalid && beat_q == LAST_BEAT) begin
      lru_touch = 1'b1;
      lru_way   = victim_q;
    end
  end

  cache_lru #(.NUM_SETS(NUM_SETS), .NUM_WAYS(NUM_WAYS)) u_lru (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_i    (req_idx),
    .way_i    (lru_way),
    .touch_i  (lru_touch),
    .valid_i  (valid_q[req_idx]),
    .victim_o (victim_way)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (req_valid) state_d = S_LOOKUP;
      S_LOOKUP: begin
        if (we_q && !WRITE_BACK)
          state_d = S_WT_WRITE;
        else if (hit)
          state_d = S_RESP;
        else if (WRITE_BACK && valid_q[req_idx][victim_way] && dirty_q[req_idx][victim_way])
          state_d = S_EVICT;
        else
          state_d = S_REFILL_REQ;
      end
      S_EVICT:      if (mem_gnt && beat_q == LAST_BEAT) state_d = S_REFILL_REQ;
      S_REFILL_REQ: if (mem_gnt) state_d = S_REFILL;
      S_REFILL:     if (mem_rvalid && beat_q == LAST_BEAT) state_d = S_RESP;
      S_WT_WRITE:   if (mem_gnt) state_d = S_RESP;
      S_RESP:       state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // Memory-side outputs decode only registered state, never the core inputs.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      S_EVICT: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_q[req_idx][victim_q], req_idx, beat_q, 2'b00};
        mem_wdata = data_q[req_idx][victim_q][beat_q];
      end
      S_REFILL_REQ: begin
        mem_req  = 1'b1;
        mem_addr = {req_tag, req_idx, {OFF_W{1'b0}}, 2'b00};
      end
      S_WT_WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
      end
      default: ;
    endcase
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign hit_count  = hit_q;
  assign miss_count = miss_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      victim_q <= '0;
      beat_q   <= '0;
      hit_q    <= '0;
      miss_q   <= '0;
      valid_q  <= '0;
      dirty_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: if (req_valid) begin
          addr_q  <= req_addr;
          we_q    <= req_we;
          wdata_q <= req_wdata;
          rdata_q <= '0;
          beat_q  <= '0;
        end
        S_LOOKUP: begin
          victim_q <= victim_way;
          if (hit) begin
            hit_q <= hit_q + 32'd1;
            if (!we_q) rdata_q <= data_q[req_idx][hit_way][req_off];
            else if (WRITE_BACK) dirty_q[req_idx][hit_way] <= 1'b1;
          end else begin
            miss_q <= miss_q + 32'd1;
          end
        end
        S_EVICT: if (mem_gnt) begin
          beat_q <= beat_q + 1'b1;
          if (beat_q == LAST_BEAT) dirty_q[req_idx][victim_q] <= 1'b0;
        end
        S_REFILL: if (mem_rvalid) begin
          beat_q <= beat_q + 1'b1;
          if (!we_q && beat_q == req_off) rdata_q <= mem_rdata;
          if (beat_q == LAST_BEAT) begin
            valid_q[req_idx][victim_q] <= 1'b1;
            dirty_q[req_idx][victim_q] <= we_q;
          end
        end
        default: ;
      endcase
    end
  end

  // Refill beats land straight in the victim way; the line only becomes
  // visible when valid/tag are written on the last beat.
  always_ff @(posedge clk) begin
    if (state_q == S_LOOKUP && hit && we_q)
      data_q[req_idx][hit_way][req_off] <= wdata_q;
    if (state_q == S_REFILL && mem_rvalid) begin
      data_q[req_idx][victim_q][beat_q] <= (we_q && beat_q == req_off) ? wdata_q : mem_rdata;
      if (beat_q == LAST_BEAT) tag_q[req_idx][victim_q] <= req_tag;
    end
  end

endmodule

// File: tb/tb_l1_cache_assoc.sv
// Directed bench: instance 0 is write-through, instance 1 is write-back.
module tb_l1_cache_assoc;

  logic        clk;
  logic        rst_n      [2];
  logic        req_valid  [2];
  logic        req_we     [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        req_ready  [2];
  logic        resp_valid [2];
  logic [31:0] resp_rdata [2];
  logic        mem_req    [2];
  logic        mem_we     [2];
  logic [31:0] mem_addr   [2];
  logic [31:0] mem_wdata  [2];
  logic        mem_gnt    [2];
  logic        mem_rvalid [2];
  logic [31:0] mem_rdata  [2];
  logic [31:0] hit_count  [2];
  logic [31:0] miss_count [2];

  l1_cache_assoc #(.WRITE_BACK(1'b0)) u_wt (
    .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_ready(req_ready[0]),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .mem_req(mem_req[0]),
    .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_gnt(mem_gnt[0]), .mem_rvalid(mem_rvalid[0]), .mem_rdata(mem_rdata[0]),
    .hit_count(hit_count[0]), .miss_count(miss_count[0]));

  l1_cache_assoc #(.WRITE_BACK(1'b1)) u_wb (
    .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_ready(req_ready[1]),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .mem_req(mem_req[1]),
    .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_gnt(mem_gnt[1]), .mem_rvalid(mem_rvalid[1]), .mem_rdata(mem_rdata[1]),
    .hit_count(hit_count[1]), .miss_count(miss_count[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Results of the most recent access.
  logic [31:0] rdata, rd_addr;
  int          lat, n_rd, memreq_cyc, wr_before_rd;
  bit          resp_ok, ready_bad, aborted;
  logic [31:0] wr_a [$];
  logic [31:0] wr_d [$];

  // Backing store: written words override the address-derived pattern.
  logic [31:0] memw [bit [32:0]];

  function automatic logic [31:0] mval(input int d, input logic [31:0] a);
    bit [32:0] k;
    k = {d[0], a};
    if (memw.exists(k)) return memw[k];
    return 32'hA0 + ((a - 32'h40) >> 2);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic access(input int d, input bit we, input logic [31:0] a, input logic [31:0] wd,
                        input bit stress, input int abort_after, input string tag);
    int beat;
    bit rd_active;
    logic [31:0] rd_base;
    n_rd = 0; rd_addr = '0; memreq_cyc = 0; lat = 0; wr_before_rd = -1;
    resp_ok = 0; ready_bad = 0; aborted = 0; rdata = '0;
    wr_a.delete(); wr_d.delete();
    beat = 0; rd_active = 0; rd_base = '0;
    @(negedge clk);
    req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = a; req_wdata[d] = wd;
    @(posedge clk); #1;
    req_valid[d] = 1'b0; req_we[d] = 1'b0;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clk);
      mem_gnt[d] = 1'b0; mem_rvalid[d] = 1'b0;
      if (resp_valid[d]) begin
        rdata = resp_rdata[d]; lat = cyc; resp_ok = 1;
        break;
      end
      if (abort_after > 0 && beat == abort_after) begin
        rst_n[d] = 1'b0; #1;
        aborted = 1;
        break;
      end
      if (req_ready[d]) ready_bad = 1;
      if (rd_active && beat < 8 && !(stress && $urandom_range(2) == 0)) begin
        mem_rvalid[d] = 1'b1;
        mem_rdata[d]  = mval(d, rd_base + 32'(beat * 4));
        beat++;
      end
      if (mem_req[d]) begin
        memreq_cyc++;
        if (!(stress && $urandom_range(2) == 0)) begin
          mem_gnt[d] = 1'b1;
          if (mem_we[d]) begin
            wr_a.push_back(mem_addr[d]); wr_d.push_back(mem_wdata[d]);
            memw[{d[0], mem_addr[d]}] = mem_wdata[d];
          end else begin
            n_rd++; rd_addr = mem_addr[d]; rd_base = mem_addr[d];
            rd_active = 1; wr_before_rd = wr_a.size();
          end
        end
      end
    end
    if (abort_after > 0) check({tag, "/aborted"}, 32'(aborted), 32'd1);
    else                 check({tag, "/done"}, 32'(resp_ok), 32'd1);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
      req_wdata[d] = '0; mem_gnt[d] = 1'b0; mem_rvalid[d] = 1'b0; mem_rdata[d] = '0;
    end
    repeat (2) @(negedge clk);
    check("rst_ready",   32'(req_ready[0]), 32'd1);
    check("rst_resp",    32'(resp_valid[0]), 32'd0);
    check("rst_memreq",  32'(mem_req[0]), 32'd0);
    check("rst_memwe",   32'(mem_we[0]), 32'd0);
    check("rst_memaddr", mem_addr[0], 32'd0);
    check("rst_memwd",   mem_wdata[0], 32'd0);
    check("rst_rdata",   resp_rdata[0], 32'd0);
    check("rst_hits",    hit_count[0], 32'd0);
    check("rst_misses",  miss_count[0], 32'd0);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;

    // Cold load then hit on the neighbouring word.
    access(0, 0, 32'h40, '0, 0, 0, "cold");
    check("cold_nrd", n_rd, 1);
    check("cold_rdaddr", rd_addr, 32'h40);
    check("cold_data", rdata, 32'hA0);
    check("cold_miss", miss_count[0], 32'd1);
    access(0, 0, 32'h44, '0, 0, 0, "hit44");
    check("hit44_lat", lat, 2);
    check("hit44_data", rdata, 32'hA1);
    check("hit44_nomem", memreq_cyc, 0);
    check("hit44_hits", hit_count[0], 32'd1);

    // Write-through store hit and re-read.
    access(0, 1, 32'h44, 32'hDEADBEEF, 0, 0, "wt_st");
    check("wt_st_nwr", wr_a.size(), 1);
    check("wt_st_addr", wr_a.size() > 0 ? wr_a[0] : 32'hX, 32'h44);
    check("wt_st_data", wr_d.size() > 0 ? wr_d[0] : 32'hX, 32'hDEADBEEF);
    check("wt_st_rdata", rdata, 32'h0);
    check("wt_st_hits", hit_count[0], 32'd2);
    access(0, 0, 32'h44, '0, 0, 0, "wt_re");
    check("wt_re_data", rdata, 32'hDEADBEEF);
    check("wt_re_nomem", memreq_cyc, 0);
    check("wt_re_hits", hit_count[0], 32'd3);

    // Store miss: one write beat, no allocation.
    access(0, 1, 32'h1000, 32'h12345678, 0, 0, "wt_sm");
    check("wt_sm_nwr", wr_a.size(), 1);
    check("wt_sm_nrd", n_rd, 0);
    check("wt_sm_miss", miss_count[0], 32'd2);
    access(0, 0, 32'h1000, '0, 0, 0, "wt_sm_ld");
    check("wt_sm_ld_nrd", n_rd, 1);
    check("wt_sm_ld_data", rdata, 32'h12345678);

    // LRU: set 2 holds 0x040 in way 0; fill the rest, re-touch 0x040, then 0x840.
    access(0, 0, 32'h240, '0, 0, 0, "l240");
    access(0, 0, 32'h440, '0, 0, 0, "l440");
    access(0, 0, 32'h640, '0, 0, 0, "l640");
    access(0, 0, 32'h040, '0, 0, 0, "l040a");
    check("lru_touch_hit", memreq_cyc, 0);
    access(0, 0, 32'h840, '0, 0, 0, "l840");
    check("lru_840_data", rdata, 32'h2A0);
    access(0, 0, 32'h640, '0, 0, 0, "l640b");
    check("lru_640_kept", n_rd, 0);
    access(0, 0, 32'h240, '0, 0, 0, "l240b");
    check("lru_240_evicted", n_rd, 1);
    access(0, 0, 32'h040, '0, 0, 0, "l040b");
    check("lru_040_hit", memreq_cyc, 0);

    // Refill with rvalid gaps; then other words of the line must hit.
    access(0, 0, 32'h206C, '0, 1, 0, "st_ld");
    check("st_ld_data", rdata, 32'h8AB);
    check("st_ld_ready", 32'(ready_bad), 32'd0);
    access(0, 0, 32'h2060, '0, 0, 0, "st_w0");
    check("st_w0_data", rdata, 32'h8A8);
    access(0, 0, 32'h207C, '0, 0, 0, "st_w7");
    check("st_w7_data", rdata, 32'h8AF);
    check("wt_hits", hit_count[0], 32'd8);
    check("wt_misses", miss_count[0], 32'd9);

    // Reset after the third refill beat abandons the line.
    access(0, 0, 32'h3000, '0, 0, 3, "abort");
    check("abort_memreq", 32'(mem_req[0]), 32'd0);
    check("abort_ready", 32'(req_ready[0]), 32'd1);
    @(negedge clk); rst_n[0] = 1'b1;
    access(0, 0, 32'h3000, '0, 0, 0, "post_abort");
    check("post_abort_nrd", n_rd, 1);
    check("post_abort_data", rdata, 32'hC90);
    check("post_abort_miss", miss_count[0], 32'd1);

    // Write-back: allocate on store miss, store hit, then evict the dirty line.
    access(1, 1, 32'h48, 32'hCAFEF00D, 0, 0, "wb_sm");
    check("wb_sm_nrd", n_rd, 1);
    check("wb_sm_rdaddr", rd_addr, 32'h40);
    check("wb_sm_nwr", wr_a.size(), 0);
    access(1, 0, 32'h48, '0, 0, 0, "wb_ld");
    check("wb_ld_data", rdata, 32'hCAFEF00D);
    check("wb_ld_lat", lat, 2);
    access(1, 1, 32'h40, 32'h11111111, 0, 0, "wb_sh");
    check("wb_sh_lat", lat, 2);
    check("wb_sh_nomem", memreq_cyc, 0);
    access(1, 0, 32'h240, '0, 0, 0, "wb240");
    access(1, 0, 32'h440, '0, 0, 0, "wb440");
    access(1, 0, 32'h640, '0, 0, 0, "wb640");
    check("wb_fill_nwr", wr_a.size(), 0);
    access(1, 0, 32'h840, '0, 1, 0, "wb_ev");
    check("wb_ev_nwr", wr_a.size(), 8);
    check("wb_ev_order", wr_before_rd, 8);
    check("wb_ev_rdaddr", rd_addr, 32'h840);
    check("wb_ev_data", rdata, 32'h2A0);
    check("wb_ev_ready", 32'(ready_bad), 32'd0);
    for (int i = 0; i < 8 && i < wr_a.size(); i++) begin
      logic [31:0] ed;
      ed = (i == 0) ? 32'h11111111 : (i == 2) ? 32'hCAFEF00D : 32'hA0 + 32'(i);
      check($sformatf("wb_ev_addr%0d", i), wr_a[i], 32'h40 + 32'(4 * i));
      check($sformatf("wb_ev_data%0d", i), wr_d[i], ed);
    end
    access(1, 0, 32'h48, '0, 0, 0, "wb_reload");
    check("wb_reload_nrd", n_rd, 1);
    check("wb_reload_nwr", wr_a.size(), 0);
    check("wb_reload_data", rdata, 32'hCAFEF00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/l1_cache_assoc.md
Name: l1_cache_assoc

Overview:
Parametrised set-associative L1 data cache. It replaces the fixed 16-set/4-way/8-word cache that had no reset.
- Adds true-LRU replacement, selectable write-through or write-back policy, and a real line-refill FSM.
- Sits between the core load/store port and the memory-bus block.
- Memory side uses a request/grant address handshake plus per-beat data valid; both sides are single-outstanding.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, word width; addresses are word-aligned and addr[1:0] is ignored.
- NUM_SETS, 16, set count; power of 2, at least 2.
- NUM_WAYS, 4, associativity; power of 2, 1 to 8.
- BLOCK_WORDS, 8, words per line; power of 2, at least 2.
- WRITE_BACK, 0, policy select. 0 = write-through, no-write-allocate. 1 = write-back, write-allocate.

Derived address fields:
- OFF_W = log2(BLOCK_WORDS), IDX_W = log2(NUM_SETS), TAG_W = ADDR_W - IDX_W - OFF_W - 2.
- Field positions: offset = addr[OFF_W+1:2], index = addr[IDX_W+OFF_W+1:OFF_W+2], tag = upper bits.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  core request present.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data.
- req_ready  out  1  request accepted on a clk edge when req_valid && req_ready.
- resp_valid  out  1  one-cycle pulse: load data valid, or store retired.
- resp_rdata  out  DATA_W  load data; 0 for stores.
- mem_req  out  1  memory transaction/beat request.
- mem_we  out  1  1 = write beat, 0 = line read.
- mem_addr  out  ADDR_W  beat address (line base for reads).
- mem_wdata  out  DATA_W  write beat data.
- mem_gnt  in  1  memory accepts the current mem_req beat this cycle.
- mem_rvalid  in  1  refill data beat valid.
- mem_rdata  in  DATA_W  refill data.
- hit_count  out  32  load+store hits; wraps at 2^32.
- miss_count  out  32  load+store misses; wraps at 2^32.

Behaviour:
- Reset, asynchronous:
  - Clears all valid, dirty and LRU state, both counters and the FSM (to IDLE).
  - Drives req_ready=1 and resp_valid=0; mem_req, mem_we, mem_addr, mem_wdata and resp_rdata all 0.
  - Data and tag arrays are not reset.
  - Reset mid-refill or mid-writeback abandons the transaction: no line is installed and mem_req drops immediately.
- FSM states: IDLE, LOOKUP, EVICT, REFILL_REQ, REFILL, WT_WRITE, RESP.
- IDLE: req_ready=1 only here. On accept, latch addr, we and wdata, then go to LOOKUP. req_valid in any other state is ignored.
- LOOKUP: compare the tag against all valid ways of the indexed set. At most one way may match; multiple matches are a design bug, flag with an assertion.
  - Load hit: latch the word, update LRU, hit_count++, go to RESP.
  - Store hit: write the word and update LRU. WRITE_BACK=1: set dirty, go to RESP. WRITE_BACK=0: go to WT_WRITE. hit_count++ in both cases.
  - Load miss: select victim. WRITE_BACK=1 and victim dirty: go to EVICT. Otherwise go to REFILL_REQ. miss_count++.
  - Store miss: WRITE_BACK=0: go to WT_WRITE with no allocation. WRITE_BACK=1: handled as a load miss, then the store is merged on install. miss_count++.
- Victim selection: the lowest-index invalid way; otherwise the way with the highest LRU age.
- LRU: per-way age of log2(NUM_WAYS) bits. On access, the accessed way gets age 0 and ways younger than it increment by 1; ages stay a permutation.
- EVICT: issues BLOCK_WORDS write beats, mem_we=1.
  - mem_addr = victim line base + 4·beat.
  - The beat advances only on mem_gnt. After the last beat, clear dirty and go to REFILL_REQ.
- REFILL_REQ: mem_req=1, mem_we=0, mem_addr = line base (offset bits 0), held until mem_gnt, then go to REFILL.
- REFILL: accept words 0..BLOCK_WORDS-1 in order, one per mem_rvalid cycle. Gaps are allowed; mem_rvalid outside REFILL is ignored.
  - On the last beat, write the line, tag, valid=1 and LRU (way = MRU).
  - Pending store: merge req_wdata and set dirty.
  - Then go to RESP; resp_rdata = the requested word, taken from the refilled data.
- WT_WRITE: single write beat (mem_addr = req addr, mem_wdata = req data), held until mem_gnt, then go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then go to IDLE with req_ready=1 on the next cycle.
- Latency, acceptance at edge T: hit load resp_valid during cycle T+2; store hit in write-back mode also T+2.
- Outputs are registered from FSM state; no combinational path exists from req_* to mem_*.

Decomposition:
- Package l1_cache_pkg holds the state enum, the clog2-derived width functions, and the field-extract functions for tag, index and offset.
- Sub-module cache_lru: per-set age array with inputs set, way, touch, and outputs victim_way plus invalid-way priority select.

Test Plan:
All scenarios use default parameters with WRITE_BACK as stated.
- Cold load:
  - Stimulus: reset, load 0x0000_0040; memory returns 0xA0..0xA7 in REFILL.
  - Required: one read request at 0x40; resp_rdata=0xA0; miss_count=1.
  - Then load 0x44: resp_valid at T+2 with 0xA1, no mem_req, hit_count=1.
- LRU replacement: fill set 2 with 5 distinct tags (0x040, 0x240, 0x440, 0x640, 0x840), re-touching 0x040 before the fifth.
  - Required: 0x240's way is evicted; a later load of 0x040 hits.
- Write-through (WRITE_BACK=0): store 0xDEAD_BEEF to 0x44 after the line is present.
  - Required: one write beat at 0x44 with data 0xDEADBEEF; reload of 0x44 hits with 0xDEADBEEF.
  - Store to an absent address: write beat only, no allocation.
- Write-back (WRITE_BACK=1): store to 0x40, then force eviction of that line.
  - Required: 8 write beats at 0x40..0x5C in order, containing the stored word, before the refill read.
- Handshake stress: random mem_gnt stalls and mem_rvalid gaps.
  - Required: beats are never skipped or duplicated; req_ready stays 0 until after resp_valid.
- Reset mid-refill: assert rst_n=0 after the 3rd refill beat.
  - Required: mem_req=0 immediately; a subsequent load of the same address misses again.
